// File: rtl/letc_core_pkg.sv
// LETC core shared types: E1->E2 and E2->W stage payloads, memory-op encodings and trap causes.
package letc_core_pkg;

    typedef enum logic [1:0] {
        MEMOP_NONE  = 2'd0,
        MEMOP_LOAD  = 2'd1,
        MEMOP_STORE = 2'd2
    } memop_e;

    typedef enum logic [1:0] {
        MEMSIZE_BYTE = 2'd0,
        MEMSIZE_HALF = 2'd1,
        MEMSIZE_WORD = 2'd2
    } memsize_e;

    typedef logic [3:0] cause_t;

    localparam cause_t CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam cause_t CAUSE_ACCESS_FAULT     = 4'd5;
    localparam cause_t CAUSE_STORE_MISALIGNED = 4'd6;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd_idx;
        logic        rd_we;
        logic [31:0] alu_result;
        memop_e      memop;
        memsize_e    memsize;
        logic        mem_signed;
        logic [31:0] rs2_val;
    } e1_to_e2_s;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd_idx;
        logic        rd_we;
        logic [31:0] rd_val;
        logic        excpt;
        cause_t      excpt_cause;
    } e2_to_w_s;

    // Reserved size encoding 3 is treated like a word access.
    function automatic logic is_misaligned(memsize_e size, logic [1:0] lane);
        logic mis;
        case (size)
            MEMSIZE_BYTE: mis = 1'b0;
            MEMSIZE_HALF: mis = lane[0];
            default:      mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/letc_core_stage_e2_if.sv
// Data-memory request/response port used by the E2 stage (master) and the memory (slave).
interface letc_core_stage_e2_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rsp_valid;
    logic [31:0] rdata;

    modport master (
        output req_valid, addr, wen, wdata, wstrb,
        input  req_ready, rsp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wstrb,
        output req_ready, rsp_valid, rdata
    );
endinterface

// File: rtl/letc_core_lsu_align.sv
// Combinational lane handling: store data replication/strobes and load byte/half extract with extension.
module letc_core_lsu_align
    import letc_core_pkg::*;
(
    input  memsize_e    st_size_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    input  memsize_e    ld_size_i,
    input  logic        ld_signed_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_val_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'b1111;
        case (st_size_i)
            MEMSIZE_BYTE: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_wstrb_o = 4'b0001 << st_lane_i;
            end
            MEMSIZE_HALF: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_wstrb_o = 4'b0011 << st_lane_i;
            end
            default: ;
        endcase
    end

    assign ld_byte = ld_rdata_i[{ld_lane_i, 3'b000} +: 8];
    assign ld_half = ld_rdata_i[{ld_lane_i[1], 4'b0000} +: 16];

    always_comb begin
        case (ld_size_i)
            MEMSIZE_BYTE: ld_val_o = {{24{ld_signed_i & ld_byte[7]}}, ld_byte};
            MEMSIZE_HALF: ld_val_o = {{16{ld_signed_i & ld_half[15]}}, ld_half};
            default:      ld_val_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/letc_core_stage_e2.sv
// LETC core second execute stage: data-memory access FSM with response timeout, plus the E2->W register.
//  state   | meaning
//  IDLE    | accepting from E1; ALU ops and misaligned traps complete here
//  REQ     | request presented, fields frozen until req_ready
//  RESP    | request accepted, waiting for response or timeout
//  DRAIN   | flushed after acceptance, swallowing the orphan response/timeout
//  HOLD    | result ready but stage stalled
module letc_core_stage_e2
    import letc_core_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  e1_to_e2_s                  i_e1_to_e2,
    output e2_to_w_s                   o_e2_to_w,
    output logic                       o_stage_ready,
    input  logic                       i_stage_flush,
    input  logic                       i_stage_stall,
    letc_core_stage_e2_if.master       dmem,
    output logic [7:0]                 o_debug
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_RESP  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic       TMO_EN  = (RSP_TIMEOUT != 0);
    localparam logic [7:0] TMO_VAL = RSP_TIMEOUT[7:0];

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    e2_to_w_s    out_q, out_d;
    e2_to_w_s    hold_q, hold_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [4:0]  rd_idx_q, rd_idx_d;
    logic        rd_we_q, rd_we_d;
    memsize_e    size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  lane_q, lane_d;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_val;
    logic        timeout;
    logic        done;
    e2_to_w_s    rsp_result;
    e2_to_w_s    in_result;
    logic        in_mis;

    letc_core_lsu_align u_align (
        .st_size_i   (i_e1_to_e2.memsize),
        .st_lane_i   (i_e1_to_e2.alu_result[1:0]),
        .st_data_i   (i_e1_to_e2.rs2_val),
        .st_wdata_o  (st_wdata),
        .st_wstrb_o  (st_wstrb),
        .ld_size_i   (size_q),
        .ld_signed_i (signed_q),
        .ld_lane_i   (lane_q),
        .ld_rdata_i  (dmem.rdata),
        .ld_val_o    (ld_val)
    );

    assign timeout = TMO_EN && (cnt_q == TMO_VAL);
    assign done    = dmem.rsp_valid || timeout;
    assign in_mis  = is_misaligned(i_e1_to_e2.memsize, i_e1_to_e2.alu_result[1:0]);

    // Completion for ops that finish in IDLE: ALU passthrough or misalignment trap.
    always_comb begin
        in_result        = '0;
        in_result.valid  = 1'b1;
        in_result.rd_idx = i_e1_to_e2.rd_idx;
        in_result.rd_val = i_e1_to_e2.alu_result;
        if (i_e1_to_e2.memop == MEMOP_NONE) begin
            in_result.rd_we = i_e1_to_e2.rd_we;
        end else begin
            in_result.excpt       = 1'b1;
            in_result.excpt_cause = (i_e1_to_e2.memop == MEMOP_LOAD) ? CAUSE_LOAD_MISALIGNED
                                                                      : CAUSE_STORE_MISALIGNED;
        end
    end

    // A timeout reports the faulting word address in rd_val.
    always_comb begin
        rsp_result        = '0;
        rsp_result.valid  = 1'b1;
        rsp_result.rd_idx = rd_idx_q;
        if (dmem.rsp_valid) begin
            if (!wen_q) begin
                rsp_result.rd_we  = rd_we_q;
                rsp_result.rd_val = ld_val;
            end
        end else begin
            rsp_result.rd_val      = addr_q;
            rsp_result.excpt       = 1'b1;
            rsp_result.excpt_cause = CAUSE_ACCESS_FAULT;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        hold_d   = hold_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rd_idx_d = rd_idx_q;
        rd_we_d  = rd_we_q;
        size_d   = size_q;
        signed_d = signed_q;
        lane_d   = lane_q;
        case (state_q)
            S_IDLE: begin
                if (i_stage_flush) begin
                    out_d.valid = 1'b0;
                end else if (!i_stage_stall) begin
                    out_d = '0;
                    if (i_e1_to_e2.valid) begin
                        if (i_e1_to_e2.memop == MEMOP_NONE || in_mis) begin
                            out_d = in_result;
                        end else begin
                            addr_d   = {i_e1_to_e2.alu_result[31:2], 2'b00};
                            wen_d    = (i_e1_to_e2.memop == MEMOP_STORE);
                            wdata_d  = st_wdata;
                            wstrb_d  = (i_e1_to_e2.memop == MEMOP_STORE) ? st_wstrb : 4'b0000;
                            rd_idx_d = i_e1_to_e2.rd_idx;
                            rd_we_d  = i_e1_to_e2.rd_we;
                            size_d   = i_e1_to_e2.memsize;
                            signed_d = i_e1_to_e2.mem_signed;
                            lane_d   = i_e1_to_e2.alu_result[1:0];
                            state_d  = S_REQ;
                        end
                    end
                end
            end
            S_REQ: begin
                if (dmem.req_ready) begin
                    cnt_d   = 8'd0;
                    state_d = i_stage_flush ? S_DRAIN : S_RESP;
                end else if (i_stage_flush) begin
                    state_d = S_IDLE;
                end
                if (i_stage_flush || !i_stage_stall) out_d.valid = 1'b0;
            end
            S_RESP: begin
                cnt_d = cnt_q + 8'd1;
                if (i_stage_flush) begin
                    out_d.valid = 1'b0;
                    state_d     = done ? S_IDLE : S_DRAIN;
                end else if (done) begin
                    if (i_stage_stall) begin
                        hold_d  = rsp_result;
                        state_d = S_HOLD;
                    end else begin
                        out_d   = rsp_result;
                        state_d = S_IDLE;
                    end
                end else if (!i_stage_stall) begin
                    out_d.valid = 1'b0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 8'd1;
                if (done) state_d = S_IDLE;
                if (i_stage_flush || !i_stage_stall) out_d.valid = 1'b0;
            end
            S_HOLD: begin
                if (i_stage_flush) begin
                    out_d.valid = 1'b0;
                    state_d     = S_IDLE;
                end else if (!i_stage_stall) begin
                    out_d   = hold_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            out_q    <= '0;
            hold_q   <= '0;
            addr_q   <= 32'd0;
            wen_q    <= 1'b0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            rd_idx_q <= 5'd0;
            rd_we_q  <= 1'b0;
            size_q   <= MEMSIZE_BYTE;
            signed_q <= 1'b0;
            lane_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            hold_q   <= hold_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rd_idx_q <= rd_idx_d;
            rd_we_q  <= rd_we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            lane_q   <= lane_d;
        end
    end

    assign o_e2_to_w      = out_q;
    assign o_stage_ready  = (state_q == S_IDLE) && !i_stage_stall;
    assign dmem.req_valid = (state_q == S_REQ);
    assign dmem.addr      = addr_q;
    assign dmem.wen       = wen_q;
    assign dmem.wdata     = wdata_q;
    assign dmem.wstrb     = wstrb_q;
    assign o_debug        = {state_q, cnt_q[4:0]};

endmodule

// File: tb/tb_letc_core_stage_e2.sv
// Randomized bench for the E2 stage against an arithmetic model of loads, stores, traps and hazards.
module tb_letc_core_stage_e2;
    import letc_core_pkg::*;

    localparam int unsigned TMO = 4;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    e1_to_e2_s e1;
    e2_to_w_s  wb;
    logic      ready;
    logic      flush = 1'b0;
    logic      stall = 1'b0;
    logic [7:0] dbg;
    int        pass_cnt = 0;
    int        chk_cnt = 0;

    letc_core_stage_e2_if dmem_if ();

    letc_core_stage_e2 #(.RSP_TIMEOUT(TMO)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_e1_to_e2    (e1),
        .o_e2_to_w     (wb),
        .o_stage_ready (ready),
        .i_stage_flush (flush),
        .i_stage_stall (stall),
        .dmem          (dmem_if),
        .o_debug       (dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] nbytes(input memsize_e sz);
        return (sz == MEMSIZE_BYTE) ? 32'd1 : (sz == MEMSIZE_HALF) ? 32'd2 : 32'd4;
    endfunction

    function automatic logic [31:0] model_load(input memsize_e sz, input logic sgn,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] nbits, v;
        nbits = 32'd8 * nbytes(sz);
        if (nbits == 32'd32) return rdata;
        v = (rdata >> (32'd8 * (addr % 32'd4))) & ((32'd1 << nbits) - 32'd1);
        if (sgn && v >= (32'd1 << (nbits - 32'd1))) v = v - (32'd1 << nbits);
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input memsize_e sz, input logic [31:0] d);
        if (sz == MEMSIZE_BYTE) return (d & 32'hFF) * 32'h01010101;
        if (sz == MEMSIZE_HALF) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [3:0] model_wstrb(input memsize_e sz, input logic [31:0] addr);
        logic [31:0] m;
        m = ((32'd1 << nbytes(sz)) - 32'd1) << (addr % 32'd4);
        return m[3:0];
    endfunction

    // Fields the spec defines; rd_val only matters when written back, cause only on a trap.
    function automatic logic [43:0] key(input e2_to_w_s r);
        return {r.valid, r.rd_idx, r.rd_we, r.excpt, r.excpt ? r.excpt_cause : 4'h0,
                r.rd_we ? r.rd_val : 32'h0};
    endfunction

    function automatic e2_to_w_s mk(input logic [4:0] rd, input logic we, input logic [31:0] val,
                                    input logic ex, input cause_t cause);
        e2_to_w_s r;
        r = '0;
        r.valid = 1'b1; r.rd_idx = rd; r.rd_we = we; r.rd_val = val;
        r.excpt = ex; r.excpt_cause = cause;
        return r;
    endfunction

    function automatic e1_to_e2_s mk_in(input logic [4:0] rd, input logic we, input logic [31:0] alu,
                                        input memop_e op, input memsize_e sz, input logic sgn,
                                        input logic [31:0] rs2);
        e1_to_e2_s s;
        s.valid = 1'b1; s.rd_idx = rd; s.rd_we = we; s.alu_result = alu;
        s.memop = op; s.memsize = sz; s.mem_signed = sgn; s.rs2_val = rs2;
        return s;
    endfunction

    // Bus-side driver: runs one aligned memory op with given latencies and reports what it saw.
    task automatic mem_txn(input e1_to_e2_s ins, input int req_lat, input int rsp_lat,
                           input logic [31:0] rdata, output e2_to_w_s res,
                           output logic [31:0] a, output logic w, output logic [31:0] wd,
                           output logic [3:0] ws, output logic proto_ok);
        proto_ok = 1'b1;
        e1 = ins;
        tick();
        e1 = '0;
        a = dmem_if.addr; w = dmem_if.wen; wd = dmem_if.wdata; ws = dmem_if.wstrb;
        for (int k = 0; k <= req_lat; k++) begin
            if (!(dmem_if.req_valid === 1'b1 && dmem_if.addr === a && dmem_if.wen === w &&
                  dmem_if.wdata === wd && dmem_if.wstrb === ws && ready === 1'b0 && wb.valid === 1'b0))
                proto_ok = 1'b0;
            if (k == req_lat) dmem_if.req_ready = 1'b1;
            tick();
        end
        dmem_if.req_ready = 1'b0;
        for (int k = 0; k < rsp_lat; k++) begin
            if (!(dmem_if.req_valid === 1'b0 && ready === 1'b0 && wb.valid === 1'b0)) proto_ok = 1'b0;
            tick();
        end
        dmem_if.rsp_valid = 1'b1;
        dmem_if.rdata = rdata;
        tick();
        dmem_if.rsp_valid = 1'b0;
        res = wb;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        chk_cnt++; if (wb !== '0) $display("FAIL reset_out got=%h exp=0", wb); else pass_cnt++;
        chk_cnt++; if (dmem_if.req_valid !== 1'b0) $display("FAIL reset_req_valid got=%b exp=0", dmem_if.req_valid); else pass_cnt++;
        chk_cnt++; if (dmem_if.wen !== 1'b0) $display("FAIL reset_wen got=%b exp=0", dmem_if.wen); else pass_cnt++;
        chk_cnt++; if (dmem_if.wstrb !== 4'h0) $display("FAIL reset_wstrb got=%h exp=0", dmem_if.wstrb); else pass_cnt++;
        chk_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else pass_cnt++;
        chk_cnt++; if (dbg[4:0] !== 5'd0) $display("FAIL reset_counter got=%0d exp=0", dbg[4:0]); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        e1_to_e2_s s;
        e2_to_w_s exp;
        e1 = mk_in(5'd5, 1'b1, 32'hDEADBEEF, MEMOP_NONE, MEMSIZE_WORD, 1'b0, 32'h0);
        tick();
        exp = mk(5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 4'h0);
        chk_cnt++; if (key(wb) !== key(exp)) $display("FAIL alu_deadbeef got=%h exp=%h", wb, exp); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            s = mk_in(5'($urandom), 1'($urandom), $urandom, MEMOP_NONE, MEMSIZE_WORD, 1'b0, $urandom);
            s.valid = ($urandom_range(0, 3) != 0);
            e1 = s;
            tick();
            if (s.valid) begin
                exp = mk(s.rd_idx, s.rd_we, s.alu_result, 1'b0, 4'h0);
                chk_cnt++; if (key(wb) !== key(exp)) $display("FAIL alu_rand got=%h exp=%h", wb, exp); else pass_cnt++;
            end else begin
                chk_cnt++; if (wb.valid !== 1'b0) $display("FAIL alu_bubble got=%b exp=0", wb.valid); else pass_cnt++;
            end
        end
        e1 = '0;
        tick();
    endtask

    task automatic test_spec_mem();
        e2_to_w_s res;
        logic [31:0] a, wd;
        logic w, ok;
        logic [3:0] ws;
        mem_txn(mk_in(5'd7, 1'b1, 32'h1003, MEMOP_LOAD, MEMSIZE_BYTE, 1'b1, 32'h0), 2, 1, 32'h80FFFFFF,
                res, a, w, wd, ws, ok);
        chk_cnt++; if (key(res) !== key(mk(5'd7, 1'b1, 32'hFFFFFF80, 1'b0, 4'h0))) $display("FAIL lb_result got=%h", res); else pass_cnt++;
        chk_cnt++; if (ok !== 1'b1) $display("FAIL lb_protocol got=%b exp=1", ok); else pass_cnt++;
        chk_cnt++; if (ready !== 1'b1) $display("FAIL lb_ready_after got=%b exp=1", ready); else pass_cnt++;
        mem_txn(mk_in(5'd3, 1'b0, 32'h2002, MEMOP_STORE, MEMSIZE_HALF, 1'b0, 32'h00001234), 3, 0, 32'h0,
                res, a, w, wd, ws, ok);
        chk_cnt++; if (a !== 32'h2000) $display("FAIL sh_addr got=%h exp=00002000", a); else pass_cnt++;
        chk_cnt++; if (wd !== 32'h12341234) $display("FAIL sh_wdata got=%h exp=12341234", wd); else pass_cnt++;
        chk_cnt++; if (ws !== 4'b1100) $display("FAIL sh_wstrb got=%b exp=1100", ws); else pass_cnt++;
        chk_cnt++; if (w !== 1'b1) $display("FAIL sh_wen got=%b exp=1", w); else pass_cnt++;
        chk_cnt++; if (ok !== 1'b1) $display("FAIL sh_stable got=%b exp=1", ok); else pass_cnt++;
        chk_cnt++; if (key(res) !== key(mk(5'd3, 1'b0, 32'h0, 1'b0, 4'h0))) $display("FAIL sh_result got=%h", res); else pass_cnt++;
        tick();
        chk_cnt++; if (wb.valid !== 1'b0) $display("FAIL sh_no_dup got=%b exp=0", wb.valid); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        e1 = mk_in(5'd9, 1'b1, 32'h3001, MEMOP_LOAD, MEMSIZE_WORD, 1'b0, 32'h0);
        tick();
        e1 = '0;
        chk_cnt++; if (dmem_if.req_valid !== 1'b0) $display("FAIL lw_mis_req got=%b exp=0", dmem_if.req_valid); else pass_cnt++;
        chk_cnt++; if (key(wb) !== key(mk(5'd9, 1'b0, 32'h0, 1'b1, CAUSE_LOAD_MISALIGNED)))
            $display("FAIL lw_mis_result got=%h", wb); else pass_cnt++;
        tick();
    endtask

    task automatic test_random_mem();
        e1_to_e2_s s;
        e2_to_w_s res, exp;
        logic [31:0] a, wd, addr;
        logic w, ok;
        logic [3:0] ws;
        memsize_e sz;
        memop_e op;
        for (int i = 0; i < 40; i++) begin
            sz = memsize_e'($urandom_range(0, 2));
            op = memop_e'($urandom_range(1, 2));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % nbytes(sz));
            s = mk_in(5'($urandom), 1'($urandom), addr, op, sz, 1'($urandom), $urandom);
            if (addr % nbytes(sz) != 0) begin
                e1 = s;
                tick();
                e1 = '0;
                exp = mk(s.rd_idx, 1'b0, 32'h0, 1'b1,
                         (op == MEMOP_LOAD) ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED);
                chk_cnt++; if (dmem_if.req_valid !== 1'b0) $display("FAIL rnd_mis_req got=%b exp=0", dmem_if.req_valid); else pass_cnt++;
                chk_cnt++; if (key(wb) !== key(exp)) $display("FAIL rnd_mis got=%h exp=%h", wb, exp); else pass_cnt++;
            end else begin
                logic [31:0] rdata;
                rdata = $urandom;
                mem_txn(s, $urandom_range(0, 3), $urandom_range(0, TMO), rdata, res, a, w, wd, ws, ok);
                if (op == MEMOP_LOAD)
                    exp = mk(s.rd_idx, s.rd_we, model_load(sz, s.mem_signed, addr, rdata), 1'b0, 4'h0);
                else
                    exp = mk(s.rd_idx, 1'b0, 32'h0, 1'b0, 4'h0);
                chk_cnt++; if (key(res) !== key(exp)) $display("FAIL rnd_result got=%h exp=%h", res, exp); else pass_cnt++;
                chk_cnt++; if (ok !== 1'b1) $display("FAIL rnd_protocol got=%b exp=1", ok); else pass_cnt++;
                chk_cnt++; if (a !== addr - addr % 32'd4) $display("FAIL rnd_addr got=%h exp=%h", a, addr - addr % 32'd4); else pass_cnt++;
                chk_cnt++; if (w !== (op == MEMOP_STORE)) $display("FAIL rnd_wen got=%b", w); else pass_cnt++;
                if (op == MEMOP_STORE) begin
                    chk_cnt++; if (wd !== model_wdata(sz, s.rs2_val)) $display("FAIL rnd_wdata got=%h exp=%h", wd, model_wdata(sz, s.rs2_val)); else pass_cnt++;
                    chk_cnt++; if (ws !== model_wstrb(sz, addr)) $display("FAIL rnd_wstrb got=%b exp=%b", ws, model_wstrb(sz, addr)); else pass_cnt++;
                end
            end
            tick();
            chk_cnt++; if (wb.valid !== 1'b0) $display("FAIL rnd_no_dup got=%b exp=0", wb.valid); else pass_cnt++;
        end
    endtask

    task automatic test_stall_alu();
        e2_to_w_s ea, eb;
        ea = mk(5'd1, 1'b1, 32'hAAAA0001, 1'b0, 4'h0);
        eb = mk(5'd2, 1'b1, 32'hBBBB0002, 1'b0, 4'h0);
        e1 = mk_in(5'd1, 1'b1, 32'hAAAA0001, MEMOP_NONE, MEMSIZE_WORD, 1'b0, 32'h0);
        tick();
        stall = 1'b1;
        e1 = mk_in(5'd2, 1'b1, 32'hBBBB0002, MEMOP_NONE, MEMSIZE_WORD, 1'b0, 32'h0);
        #1;
        chk_cnt++; if (ready !== 1'b0) $display("FAIL stall_ready got=%b exp=0", ready); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_cnt++; if (key(wb) !== key(ea)) $display("FAIL stall_hold got=%h exp=%h", wb, ea); else pass_cnt++;
        end
        stall = 1'b0;
        tick();
        e1 = '0;
        chk_cnt++; if (key(wb) !== key(eb)) $display("FAIL stall_release got=%h exp=%h", wb, eb); else pass_cnt++;
        tick();
        chk_cnt++; if (wb.valid !== 1'b0) $display("FAIL stall_no_dup got=%b exp=0", wb.valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        logic seen_valid;
        // Flush while waiting for the response.
        e1 = mk_in(5'd4, 1'b1, 32'h5000, MEMOP_LOAD, MEMSIZE_WORD, 1'b0, 32'h0);
        tick();
        e1 = '0;
        dmem_if.req_ready = 1'b1;
        tick();
        dmem_if.req_ready = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen_valid = wb.valid;
        chk_cnt++; if (ready !== 1'b0) $display("FAIL drain_ready got=%b exp=0", ready); else pass_cnt++;
        tick();
        seen_valid |= wb.valid;
        dmem_if.rsp_valid = 1'b1;
        dmem_if.rdata = 32'h12345678;
        tick();
        dmem_if.rsp_valid = 1'b0;
        seen_valid |= wb.valid;
        chk_cnt++; if (seen_valid !== 1'b0) $display("FAIL drain_valid got=%b exp=0", seen_valid); else pass_cnt++;
        chk_cnt++; if (ready !== 1'b1) $display("FAIL drain_exit got=%b exp=1", ready); else pass_cnt++;
        e1 = mk_in(5'd6, 1'b1, 32'h0BADF00D, MEMOP_NONE, MEMSIZE_WORD, 1'b0, 32'h0);
        tick();
        e1 = '0;
        chk_cnt++; if (key(wb) !== key(mk(5'd6, 1'b1, 32'h0BADF00D, 1'b0, 4'h0))) $display("FAIL after_flush got=%h", wb); else pass_cnt++;
        // Flush before the request is accepted.
        e1 = mk_in(5'd8, 1'b1, 32'h6000, MEMOP_STORE, MEMSIZE_WORD, 1'b0, 32'h1);
        tick();
        e1 = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_cnt++; if (dmem_if.req_valid !== 1'b0) $display("FAIL flush_req_drop got=%b exp=0", dmem_if.req_valid); else pass_cnt++;
        chk_cnt++; if (ready !== 1'b1) $display("FAIL flush_req_idle got=%b exp=1", ready); else pass_cnt++;
        chk_cnt++; if (wb.valid !== 1'b0) $display("FAIL flush_req_out got=%b exp=0", wb.valid); else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        int seen;
        e2_to_w_s exp;
        exp = mk(5'd11, 1'b0, 32'h0, 1'b1, CAUSE_ACCESS_FAULT);
        // Counter starts at 0 on entering RESP; the fault fires in the cycle it equals RSP_TIMEOUT.
        e1 = mk_in(5'd11, 1'b1, 32'h7000, MEMOP_LOAD, MEMSIZE_WORD, 1'b0, 32'h0);
        tick();
        e1 = '0;
        dmem_if.req_ready = 1'b1;
        tick();
        dmem_if.req_ready = 1'b0;
        seen = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (wb.valid === 1'b1) begin
                seen = j;
                break;
            end
        end
        chk_cnt++; if (seen != TMO + 1) $display("FAIL timeout_latency got=%0d exp=%0d", seen, TMO + 1); else pass_cnt++;
        chk_cnt++; if (key(wb) !== key(exp)) $display("FAIL timeout_result got=%h exp=%h", wb, exp); else pass_cnt++;
        tick();
        // Same again with the stage stalled as the fault completes.
        e1 = mk_in(5'd11, 1'b1, 32'h7000, MEMOP_LOAD, MEMSIZE_WORD, 1'b0, 32'h0);
        tick();
        e1 = '0;
        dmem_if.req_ready = 1'b1;
        tick();
        dmem_if.req_ready = 1'b0;
        for (int j = 0; j < int'(TMO); j++) tick();
        chk_cnt++; if (dbg[4:0] !== 5'(TMO)) $display("FAIL timeout_count got=%0d exp=%0d", dbg[4:0], TMO); else pass_cnt++;
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_cnt++; if (wb.valid !== 1'b0 || ready !== 1'b0)
                $display("FAIL hold_wait got valid=%b ready=%b exp 0/0", wb.valid, ready); else pass_cnt++;
        end
        stall = 1'b0;
        tick();
        chk_cnt++; if (key(wb) !== key(exp)) $display("FAIL hold_release got=%h exp=%h", wb, exp); else pass_cnt++;
        tick();
        chk_cnt++; if (wb.valid !== 1'b0) $display("FAIL hold_no_dup got=%b exp=0", wb.valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        e1 = mk_in(5'd12, 1'b1, 32'h8000, MEMOP_LOAD, MEMSIZE_WORD, 1'b0, 32'h0);
        tick();
        e1 = '0;
        dmem_if.req_ready = 1'b1;
        tick();
        dmem_if.req_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk_cnt++; if (dmem_if.req_valid !== 1'b0) $display("FAIL rst_mid_req got=%b exp=0", dmem_if.req_valid); else pass_cnt++;
        chk_cnt++; if (ready !== 1'b1) $display("FAIL rst_mid_ready got=%b exp=1", ready); else pass_cnt++;
        chk_cnt++; if (wb !== '0) $display("FAIL rst_mid_out got=%h exp=0", wb); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        e1 = '0;
        dmem_if.req_ready = 1'b0;
        dmem_if.rsp_valid = 1'b0;
        dmem_if.rdata = 32'h0;
        test_reset();
        test_alu();
        test_spec_mem();
        test_misaligned();
        test_random_mem();
        test_stall_alu();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
